// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package mux_arb_pkg;

    // Two-state arbiter: nobody granted, or one requester owns the mux.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Widest grant vector the helper below can encode (N <= 16).
    localparam int unsigned OH_MAX = 16;

    // Binary index of a one-hot vector; an all-zero input maps to 0.
    function automatic logic [3:0] onehot2bin(input logic [OH_MAX-1:0] oh);
        logic [3:0] b;
        b = '0;
        for (int i = 0; i < OH_MAX; i++) begin
            if (oh[i]) begin
                b = b | 4'(i);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotated priority search: first set req bit at or after ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; an optional index can be masked out of the search.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 excl_en,
    input  logic [$clog2(N)-1:0] excl_idx,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] cand;
    int            cand_int;

    // Walk ptr, ptr+1, ... modulo N and keep the first eligible requester.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = '0;
        cand_int = 0;
        for (int k = 0; k < N; k++) begin
            cand_int = int'(ptr) + k;
            if (cand_int >= N) begin
                cand_int = cand_int - N;
            end
            cand = PW'(cand_int);
            if (!found && req[cand] && !(excl_en && (cand == excl_idx))) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one N:1 mux; forces rotation after HOLD_MAX cycles.
// Latency: req -> gnt/sel one cycle; y follows the registered sel combinationally.
// Backpressure: a requester keeps the grant while req stays high, up to HOLD_MAX when others wait.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int DW       = 1,
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*DW-1:0]      din,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] sel,
    output logic [DW-1:0]        y,
    output logic                 y_valid
);

    localparam int PW = $clog2(N);
    localparam int HW = $clog2(HOLD_MAX + 1);

    arb_state_t    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [PW-1:0] sel_q, sel_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          vld_q, vld_d;

    logic [PW-1:0] nxt_g;
    logic          hold_expired;
    logic [PW-1:0] pick_ptr;
    logic          pick_excl_en;
    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic          grant_new;

    logic [DW-1:0] din_arr [N];

    // Index after the current owner, wrapping N-1 -> 0.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] g);
        return (g == PW'(N - 1)) ? '0 : g + PW'(1);
    endfunction

    // Choose where the search starts and whether the current owner is skipped.
    always_comb begin
        nxt_g        = next_idx(sel_q);
        hold_expired = (hold_cnt_q >= HW'(HOLD_MAX));
        pick_ptr     = ptr_q;
        pick_excl_en = 1'b0;
        if (state_q == BUSY) begin
            if (!req[sel_q]) begin
                pick_ptr = nxt_g;
            end else if (hold_expired) begin
                pick_ptr     = nxt_g;
                pick_excl_en = 1'b1;
            end
        end
    end

    rr_pick #(
        .N (N)
    ) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .excl_en  (pick_excl_en),
        .excl_idx (sel_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // Next-state: release, hold counting, forced rotation and fresh grants.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        vld_d      = vld_q;
        grant_new  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_new = 1'b1;
                end
            end
            BUSY: begin
                if (!req[sel_q]) begin
                    // Owner released: advance past it and hand over without a bubble.
                    ptr_d = nxt_g;
                    if (pick_found) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        vld_d   = 1'b0;
                    end
                end else if (!hold_expired) begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end else if (pick_found) begin
                    // Hold limit reached and someone else is waiting: rotate.
                    ptr_d     = nxt_g;
                    grant_new = 1'b1;
                end else begin
                    // Sole requester keeps the mux; restart its hold window.
                    hold_cnt_d = HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (grant_new) begin
            state_d    = BUSY;
            gnt_d      = {{(N-1){1'b0}}, 1'b1} << pick_idx;
            sel_d      = PW'(onehot2bin(OH_MAX'(gnt_d)));
            vld_d      = 1'b1;
            hold_cnt_d = HW'(1);
        end
    end

    // Arbiter state registers; reset drops the grant immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            sel_q      <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            vld_q      <= vld_d;
        end
    end

    // Unpack the flat data bus into one lane per requester.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            din_arr[i] = din[i*DW +: DW];
        end
    end

    // Shared mux: granted lane while busy, zero otherwise.
    always_comb begin
        y = vld_q ? din_arr[sel_q] : '0;
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y_valid = vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
`timescale 1ns/1ps
module tb_mux_rr_arbiter;

    localparam int N        = 4;
    localparam int DW       = 1;
    localparam int HOLD_MAX = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] din = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [0:0] y;
    logic       y_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] din;
        logic [3:0] gnt;
    } vec_t;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic       y;
        int         id;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    always #7.5 clk = ~clk;

    mux_rr_arbiter #(
        .N        (N),
        .DW       (DW),
        .HOLD_MAX (HOLD_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Append `count` vectors with the same request and expected grant, random data.
    task automatic add(input logic [3:0] r, input logic [3:0] g, input int count);
        for (int i = 0; i < count; i++) begin
            vec_t v;
            v.req = r;
            v.din = 4'($urandom_range(0, 15));
            v.gnt = g;
            vecs.push_back(v);
        end
    endtask

    // Structural properties that must hold every cycle.
    task automatic invariants(input int id);
        logic [3:0] d;
        int         k;
        d = din;
        k = 0;
        check($sformatf("v%0d_onehot0", id), 32'($onehot0(gnt)), 32'd1);
        check($sformatf("v%0d_vld_vs_gnt", id), 32'(y_valid), 32'(gnt != 4'b0000));
        if (y_valid) begin
            for (int b = 0; b < 4; b++) begin
                if (gnt[b]) k = b;
            end
            check($sformatf("v%0d_sel_index", id), 32'(sel), 32'(k));
            check($sformatf("v%0d_y_mux", id), 32'(y), 32'(d[sel]));
        end else begin
            check($sformatf("v%0d_y_idle", id), 32'(y), 32'd0);
        end
    endtask

    // Drive each vector, queue its expectation, compare after the edge.
    task automatic run(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            exp_t       e;
            exp_t       got;
            logic [3:0] d;
            req   = vecs[i].req;
            din   = vecs[i].din;
            d     = vecs[i].din;
            e.gnt = vecs[i].gnt;
            e.vld = (e.gnt != 4'b0000);
            e.sel = idx_of(e.gnt);
            e.y   = e.vld ? d[e.sel] : 1'b0;
            e.id  = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            got = sb.pop_front();
            check($sformatf("v%0d_gnt", got.id), 32'(gnt), 32'(got.gnt));
            check($sformatf("v%0d_valid", got.id), 32'(y_valid), 32'(got.vld));
            if (got.vld) begin
                check($sformatf("v%0d_sel", got.id), 32'(sel), 32'(got.sel));
            end
            check($sformatf("v%0d_y", got.id), 32'(y), 32'(got.y));
            invariants(got.id);
        end
    endtask

    initial begin
        int split;
        rst = 1'b0;
        req = 4'b1111;
        din = 4'b1111;

        // First grant after reset, then two requesters under the hold limit.
        add(4'b1111, 4'b0001, 1);
        add(4'b0011, 4'b0001, 7);
        add(4'b0011, 4'b0010, 8);
        add(4'b0011, 4'b0001, 1);
        // Owner 0 drops, sole requester 2 is never cut off.
        add(4'b0100, 4'b0100, 20);
        // 2 releases, ptr=3, search wraps to 0.
        add(4'b0001, 4'b0001, 1);
        // Everyone gone: back to idle, ptr=1.
        add(4'b0000, 4'b0000, 2);
        add(4'b1111, 4'b0010, 2);
        split = vecs.size();
        // After a mid-grant reset: round robin with one-cycle drops, no bubble.
        add(4'b1111, 4'b0001, 2);
        add(4'b1110, 4'b0010, 1);
        add(4'b1111, 4'b0010, 1);
        add(4'b1101, 4'b0100, 1);
        add(4'b1111, 4'b0100, 1);
        add(4'b1011, 4'b1000, 1);
        add(4'b1111, 4'b1000, 1);
        add(4'b0111, 4'b0001, 1);
        add(4'b1111, 4'b0001, 1);

        repeat (2) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_valid", 32'(y_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);

        #3 rst = 1'b1;
        run(0, split);

        // Assert reset between edges while busy; outputs must clear at once.
        #3 rst = 1'b0;
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_valid", 32'(y_valid), 32'd0);
        check("async_sel", 32'(sel), 32'd0);
        check("async_y", 32'(y), 32'd0);
        req = 4'b1111;
        @(posedge clk);
        #1;
        check("held_rst_gnt", 32'(gnt), 32'd0);
        #3 rst = 1'b1;
        run(split, vecs.size());

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
